// File: rtl/pipeline_pkg.sv
// Shared types for the RV32I execute stage: ALU opcodes, forwarding selects,
// branch conditions, divider FSM states, the D->E register layout and helpers.
package pipeline_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_W      = 2'b01,
    FWD_M      = 2'b10,
    FWD_RF_ALT = 2'b11
  } fwd_sel_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // An all-zero value of this struct is the pipeline bubble.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic            reg_wr_en;
    logic            dm_wr_en;
    logic            sel_result;
    logic [3:0]      alu_ctrl;
    logic            sel_alu_src;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic [2:0]      funct3;
    logic            mdu;
  } e_reg_t;

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                               input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] w,
                                               input logic [XLEN-1:0] m);
    case (sel)
      FWD_W:   return w;
      FWD_M:   return m;
      default: return rf;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      default:  return '0;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_mdu.sv
// M-extension unit: single-cycle multiplies and a 32-step restoring divider.
// Handshake: req is held high while E holds a divide; the result is valid
// while state == DIV_DONE. Multiply results are valid combinationally.
module mdu
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             req,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [2:0]       funct3,
  output div_state_t       state,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] rem_q, quot_q, div_q;
  logic [4:0]      count_q;
  logic            a_neg_q, b_neg_q, zero_q, rem_sel_q;

  logic            sgn;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [63:0]     a_ext, b_ext, prod;
  logic [XLEN-1:0] mul_result, q_fix, r_fix;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [63:0] div_step(input logic [XLEN-1:0] r,
                                           input logic [XLEN-1:0] q,
                                           input logic [XLEN-1:0] d);
    logic [32:0] trial;
    trial = {r, q[31]} - {1'b0, d};
    if (trial[32]) return {r[30:0], q[31], q[30:0], 1'b0};
    else           return {trial[31:0], q[30:0], 1'b1};
  endfunction

  assign sgn   = ~funct3[0];
  assign abs_a = (sgn && a[31]) ? -a : a;
  assign abs_b = (sgn && b[31]) ? -b : b;

  assign a_ext = {{32{a[31] & (funct3[1:0] != 2'b11)}}, a};
  assign b_ext = {{32{b[31] & (funct3[1:0] == 2'b01)}}, b};
  assign prod  = a_ext * b_ext;
  assign mul_result = (funct3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

  // A zero divisor keeps the all-ones quotient unsigned regardless of sign.
  assign q_fix  = ((a_neg_q ^ b_neg_q) && !zero_q) ? -quot_q : quot_q;
  assign r_fix  = a_neg_q ? -rem_q : rem_q;
  assign result = funct3[2] ? (rem_sel_q ? r_fix : q_fix) : mul_result;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= DIV_IDLE;
      rem_q     <= '0;
      quot_q    <= '0;
      div_q     <= '0;
      count_q   <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      zero_q    <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (req) begin
          {rem_q, quot_q} <= div_step('0, abs_a, abs_b);
          div_q     <= abs_b;
          count_q   <= 5'd1;
          a_neg_q   <= sgn & a[31];
          b_neg_q   <= sgn & b[31];
          zero_q    <= (b == '0);
          rem_sel_q <= funct3[1];
          state     <= DIV_RUN;
        end
        DIV_RUN: begin
          {rem_q, quot_q} <= div_step(rem_q, quot_q, div_q);
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) state <= DIV_DONE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute.sv
// RV32I execute stage: D->E register, forwarding, ALU, branch resolution.
// Define RV_MDU_EN to build the M-extension unit with its stalling divider.
module execute
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush_E,
  input  logic [XLEN-1:0]  i_pc_D,
  input  logic [XLEN-1:0]  i_pc_plus4_D,
  input  logic [XLEN-1:0]  i_rd1_D,
  input  logic [XLEN-1:0]  i_rd2_D,
  input  logic [XLEN-1:0]  i_imm_ext_D,
  input  logic [4:0]       i_rs1_addr_D,
  input  logic [4:0]       i_rs2_addr_D,
  input  logic [4:0]       i_register_file_wr_addr_D,
  input  logic             i_register_file_wr_en_D,
  input  logic             i_data_memory_wr_en_D,
  input  logic             i_sel_result_D,
  input  logic [3:0]       i_ALU_control_D,
  input  logic             i_sel_ALU_src_D,
  input  logic             i_branch_D,
  input  logic             i_jump_D,
  input  logic             i_jalr_D,
  input  logic [2:0]       i_funct3_D,
  input  logic             i_mdu_D,
  input  logic [1:0]       i_forward_a_E,
  input  logic [1:0]       i_forward_b_E,
  input  logic [XLEN-1:0]  i_result_W,
  input  logic [XLEN-1:0]  i_ALU_output_M,
  output logic [XLEN-1:0]  o_ALU_output_E,
  output logic [XLEN-1:0]  o_wr_data_E,
  output logic [XLEN-1:0]  o_pc_target_E,
  output logic [4:0]       o_register_file_wr_addr_E,
  output logic [4:0]       o_rs1_addr_E,
  output logic [4:0]       o_rs2_addr_E,
  output logic             o_register_file_wr_en_E,
  output logic             o_data_memory_wr_en_E,
  output logic             o_sel_result_E,
  output logic             o_pc_src_E,
  output logic             o_busy_E
);

  e_reg_t          e_q, e_d;
  logic            busy;
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, exec_result, target_base;

  always_comb begin
    e_d             = '0;
    e_d.pc          = i_pc_D;
    e_d.pc_plus4    = i_pc_plus4_D;
    e_d.rd1         = i_rd1_D;
    e_d.rd2         = i_rd2_D;
    e_d.imm         = i_imm_ext_D;
    e_d.rs1_addr    = i_rs1_addr_D;
    e_d.rs2_addr    = i_rs2_addr_D;
    e_d.rd_addr     = i_register_file_wr_addr_D;
    e_d.reg_wr_en   = i_register_file_wr_en_D;
    e_d.dm_wr_en    = i_data_memory_wr_en_D;
    e_d.sel_result  = i_sel_result_D;
    e_d.alu_ctrl    = i_ALU_control_D;
    e_d.sel_alu_src = i_sel_ALU_src_D;
    e_d.branch      = i_branch_D;
    e_d.jump        = i_jump_D;
    e_d.jalr        = i_jalr_D;
    e_d.funct3      = i_funct3_D;
    e_d.mdu         = i_mdu_D;
  end

  // Flush wins over the divide hold so a squashed divide never completes.
  always_ff @(posedge clk) begin
    if (rst || i_flush_E) e_q <= '0;
    else if (!busy)       e_q <= e_d;
  end

  assign src_a      = fwd_mux(i_forward_a_E, e_q.rd1, i_result_W, i_ALU_output_M);
  assign fwd_b      = fwd_mux(i_forward_b_E, e_q.rd2, i_result_W, i_ALU_output_M);
  assign src_b      = e_q.sel_alu_src ? e_q.imm : fwd_b;
  assign alu_result = alu_compute(e_q.alu_ctrl, src_a, src_b);

`ifdef RV_MDU_EN
  div_state_t      mdu_state;
  logic [XLEN-1:0] mdu_result;
  logic            div_req;

  assign div_req = e_q.mdu & e_q.funct3[2];

  mdu u_mdu (
    .clk    (clk),
    .rst    (rst),
    .abort  (i_flush_E),
    .req    (div_req),
    .a      (src_a),
    .b      (fwd_b),
    .funct3 (e_q.funct3),
    .state  (mdu_state),
    .result (mdu_result)
  );

  assign busy        = div_req & (mdu_state != DIV_DONE);
  assign exec_result = e_q.mdu ? mdu_result : alu_result;
`else
  logic unused_mdu;
  assign unused_mdu  = e_q.mdu;
  assign busy        = 1'b0;
  assign exec_result = alu_result;
`endif

  assign target_base = e_q.jalr ? src_a : e_q.pc;
  assign o_pc_target_E = (target_base + e_q.imm) & ~{{(XLEN-1){1'b0}}, e_q.jalr};

  assign o_ALU_output_E            = e_q.jump ? e_q.pc_plus4 : exec_result;
  assign o_wr_data_E               = fwd_b;
  assign o_register_file_wr_addr_E = e_q.rd_addr;
  assign o_rs1_addr_E              = e_q.rs1_addr;
  assign o_rs2_addr_E              = e_q.rs2_addr;
  assign o_sel_result_E            = e_q.sel_result;
  assign o_register_file_wr_en_E   = e_q.reg_wr_en & ~busy;
  assign o_data_memory_wr_en_E     = e_q.dm_wr_en & ~busy;
  assign o_pc_src_E = (e_q.jump | (e_q.branch & branch_taken(e_q.funct3, src_a, fwd_b))) & ~busy;
  assign o_busy_E   = busy;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage; divide and multiply checks are built
// only when RV_MDU_EN is defined, otherwise the ignored-MDU path is checked.
module tb_execute;
  import pipeline_pkg::*;

  logic        clk, rst, i_flush_E;
  logic [31:0] i_pc_D, i_pc_plus4_D, i_rd1_D, i_rd2_D, i_imm_ext_D;
  logic [4:0]  i_rs1_addr_D, i_rs2_addr_D, i_register_file_wr_addr_D;
  logic        i_register_file_wr_en_D, i_data_memory_wr_en_D, i_sel_result_D;
  logic [3:0]  i_ALU_control_D;
  logic        i_sel_ALU_src_D, i_branch_D, i_jump_D, i_jalr_D;
  logic [2:0]  i_funct3_D;
  logic        i_mdu_D;
  logic [1:0]  i_forward_a_E, i_forward_b_E;
  logic [31:0] i_result_W, i_ALU_output_M;
  logic [31:0] o_ALU_output_E, o_wr_data_E, o_pc_target_E;
  logic [4:0]  o_register_file_wr_addr_E, o_rs1_addr_E, o_rs2_addr_E;
  logic        o_register_file_wr_en_E, o_data_memory_wr_en_E, o_sel_result_E;
  logic        o_pc_src_E, o_busy_E;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Shift / compare / undefined-op table: op, A (rd1), B (imm), result
  logic [3:0]  t_op[7]  = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_OR, 4'hF};
  logic [31:0] t_a[7]   = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0, 32'h5};
  logic [31:0] t_b[7]   = '{32'h24, 32'h24, 32'h3F, 32'h1, 32'h1, 32'h0F, 32'h7};
  logic [31:0] t_exp[7] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h1, 32'h0, 32'hFF, 32'h0};

  execute dut (
    .clk(clk), .rst(rst), .i_flush_E(i_flush_E),
    .i_pc_D(i_pc_D), .i_pc_plus4_D(i_pc_plus4_D), .i_rd1_D(i_rd1_D), .i_rd2_D(i_rd2_D),
    .i_imm_ext_D(i_imm_ext_D), .i_rs1_addr_D(i_rs1_addr_D), .i_rs2_addr_D(i_rs2_addr_D),
    .i_register_file_wr_addr_D(i_register_file_wr_addr_D),
    .i_register_file_wr_en_D(i_register_file_wr_en_D), .i_data_memory_wr_en_D(i_data_memory_wr_en_D),
    .i_sel_result_D(i_sel_result_D), .i_ALU_control_D(i_ALU_control_D),
    .i_sel_ALU_src_D(i_sel_ALU_src_D), .i_branch_D(i_branch_D), .i_jump_D(i_jump_D),
    .i_jalr_D(i_jalr_D), .i_funct3_D(i_funct3_D), .i_mdu_D(i_mdu_D),
    .i_forward_a_E(i_forward_a_E), .i_forward_b_E(i_forward_b_E),
    .i_result_W(i_result_W), .i_ALU_output_M(i_ALU_output_M),
    .o_ALU_output_E(o_ALU_output_E), .o_wr_data_E(o_wr_data_E), .o_pc_target_E(o_pc_target_E),
    .o_register_file_wr_addr_E(o_register_file_wr_addr_E), .o_rs1_addr_E(o_rs1_addr_E),
    .o_rs2_addr_E(o_rs2_addr_E), .o_register_file_wr_en_E(o_register_file_wr_en_E),
    .o_data_memory_wr_en_E(o_data_memory_wr_en_E), .o_sel_result_E(o_sel_result_E),
    .o_pc_src_E(o_pc_src_E), .o_busy_E(o_busy_E)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    i_flush_E = 1'b0;
    i_pc_D = '0; i_pc_plus4_D = '0; i_rd1_D = '0; i_rd2_D = '0; i_imm_ext_D = '0;
    i_rs1_addr_D = '0; i_rs2_addr_D = '0; i_register_file_wr_addr_D = '0;
    i_register_file_wr_en_D = 1'b0; i_data_memory_wr_en_D = 1'b0; i_sel_result_D = 1'b0;
    i_ALU_control_D = ALU_ADD; i_sel_ALU_src_D = 1'b0;
    i_branch_D = 1'b0; i_jump_D = 1'b0; i_jalr_D = 1'b0; i_funct3_D = '0; i_mdu_D = 1'b0;
    i_forward_a_E = FWD_RF; i_forward_b_E = FWD_RF; i_result_W = '0; i_ALU_output_M = '0;
  endtask

  task automatic set_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    clear_d();
    i_mdu_D = 1'b1; i_funct3_D = f3; i_rd1_D = a; i_rd2_D = b;
    i_register_file_wr_en_D = 1'b1;
  endtask

  // Scoreboard
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  // Counts busy cycles (bounded) and then checks the released result.
  task automatic measure(input string tag, input logic [31:0] result);
    int   n;
    logic leaked;
    n = 0;
    leaked = 1'b0;
    expect_val(32); expect_val(0); expect_val(result); expect_val(1);
    while (o_busy_E === 1'b1 && n < 40) begin
      leaked = leaked | o_register_file_wr_en_E | o_pc_src_E | o_data_memory_wr_en_E;
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n);
    check({tag, "_en_during_busy"}, {31'd0, leaked});
    check({tag, "_result"}, o_ALU_output_E);
    check({tag, "_wr_en_done"}, {31'd0, o_register_file_wr_en_E});
  endtask

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1;
    clear_d();
    repeat (3) tick();
    expect_val(0); expect_val(0); expect_val(0); expect_val(0); expect_val(0);
    check("rst_alu_out", o_ALU_output_E);
    check("rst_wr_en", {31'd0, o_register_file_wr_en_E});
    check("rst_pc_src", {31'd0, o_pc_src_E});
    check("rst_busy", {31'd0, o_busy_E});
    check("rst_target", o_pc_target_E);
    rst = 1'b0;

    // ADD with immediate; control passes through
    clear_d();
    i_rd1_D = 5; i_imm_ext_D = 7; i_sel_ALU_src_D = 1'b1;
    i_register_file_wr_en_D = 1'b1; i_register_file_wr_addr_D = 5'd9; i_rs1_addr_D = 5'd4;
    expect_val(12); expect_val(1); expect_val(9); expect_val(4);
    tick();
    check("add_imm", o_ALU_output_E);
    check("add_wr_en", {31'd0, o_register_file_wr_en_E});
    check("add_wr_addr", {27'd0, o_register_file_wr_addr_E});
    check("add_rs1_addr", {27'd0, o_rs1_addr_E});

    // SUB with A forwarded from M, B select 11 behaving as regfile
    clear_d();
    i_ALU_control_D = ALU_SUB; i_rd1_D = 32'h99; i_rd2_D = 3;
    i_forward_a_E = 2'b10; i_forward_b_E = 2'b11; i_ALU_output_M = 32'h10; i_result_W = 32'h55;
    expect_val(32'hD); expect_val(3);
    tick();
    check("sub_fwd_m", o_ALU_output_E);
    check("sub_wr_data_rf", o_wr_data_E);

    // XOR with B forwarded from W
    clear_d();
    i_ALU_control_D = ALU_XOR; i_rd1_D = 32'hF0F0; i_rd2_D = 32'h1234;
    i_forward_b_E = 2'b01; i_result_W = 32'h0FF0; i_ALU_output_M = 32'h7777;
    expect_val(32'hFF00); expect_val(32'h0FF0);
    tick();
    check("xor_fwd_w", o_ALU_output_E);
    check("xor_wr_data_w", o_wr_data_E);

    // Shifts, compares and an undefined opcode
    for (int i = 0; i < 7; i++) begin
      clear_d();
      i_ALU_control_D = t_op[i]; i_rd1_D = t_a[i]; i_imm_ext_D = t_b[i]; i_sel_ALU_src_D = 1'b1;
      expect_val(t_exp[i]);
      tick();
      check($sformatf("alu_table_%0d", i), o_ALU_output_E);
    end

    // Random register-register ops against a small model
    for (int i = 0; i < 6; i++) begin
      clear_d();
      rop = 4'($urandom_range(0, 4));
      ra = $urandom; rb = $urandom;
      i_ALU_control_D = rop; i_rd1_D = ra; i_rd2_D = rb;
      expect_val(model_alu(rop, ra, rb));
      tick();
      check($sformatf("alu_rand_%0d", i), o_ALU_output_E);
    end

    // BLT taken on signed compare
    clear_d();
    i_branch_D = 1'b1; i_funct3_D = F3_BLT; i_rd1_D = 32'hFFFF_FFFF; i_rd2_D = 1;
    i_pc_D = 32'h100; i_imm_ext_D = 32'h20;
    expect_val(1); expect_val(32'h120);
    tick();
    check("blt_pc_src", {31'd0, o_pc_src_E});
    check("blt_target", o_pc_target_E);

    // BLTU with the same operands is not taken
    clear_d();
    i_branch_D = 1'b1; i_funct3_D = F3_BLTU; i_rd1_D = 32'hFFFF_FFFF; i_rd2_D = 1;
    expect_val(0);
    tick();
    check("bltu_pc_src", {31'd0, o_pc_src_E});

    // funct3 010 is never taken, even on equal operands
    clear_d();
    i_branch_D = 1'b1; i_funct3_D = 3'b010; i_rd1_D = 5; i_rd2_D = 5;
    expect_val(0);
    tick();
    check("br010_pc_src", {31'd0, o_pc_src_E});

    // JALR: target from A with bit 0 cleared, link value on ALU output
    clear_d();
    i_jump_D = 1'b1; i_jalr_D = 1'b1; i_rd1_D = 32'h1001; i_imm_ext_D = 2;
    i_pc_D = 32'h200; i_pc_plus4_D = 32'h204; i_sel_ALU_src_D = 1'b1;
    expect_val(32'h1002); expect_val(32'h204); expect_val(1);
    tick();
    check("jalr_target", o_pc_target_E);
    check("jalr_link", o_ALU_output_E);
    check("jalr_pc_src", {31'd0, o_pc_src_E});

    // Flush loads a bubble instead of the decode instruction
    clear_d();
    i_rd1_D = 3; i_rd2_D = 4; i_register_file_wr_en_D = 1'b1; i_data_memory_wr_en_D = 1'b1;
    i_flush_E = 1'b1;
    expect_val(0); expect_val(0); expect_val(0);
    tick();
    i_flush_E = 1'b0;
    check("flush_alu_out", o_ALU_output_E);
    check("flush_wr_en", {31'd0, o_register_file_wr_en_E});
    check("flush_dm_wr_en", {31'd0, o_data_memory_wr_en_E});

`ifdef RV_MDU_EN
    // Multiplies complete in the same cycle
    set_mdu(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_val(32'h1); expect_val(0); tick();
    check("mul", o_ALU_output_E); check("mul_busy", {31'd0, o_busy_E});
    set_mdu(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_val(32'h0); tick();
    check("mulh", o_ALU_output_E);
    set_mdu(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_val(32'hFFFF_FFFF); tick();
    check("mulhsu", o_ALU_output_E);
    set_mdu(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_val(32'hFFFF_FFFE); tick();
    check("mulhu", o_ALU_output_E);

    // Back-to-back divides, each queued in D while the previous one runs
    set_mdu(3'b100, 32'hFFFF_FFF9, 32'd2); tick();
    set_mdu(3'b110, 32'hFFFF_FFF9, 32'd2);
    measure("div_neg", 32'hFFFF_FFFD);
    tick();
    set_mdu(3'b101, 32'd7, 32'd0);
    measure("rem_neg", 32'hFFFF_FFFF);
    tick();
    set_mdu(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    measure("divu_zero", 32'hFFFF_FFFF);
    tick();
    set_mdu(3'b100, 32'hFFFF_FFF9, 32'd0);
    measure("div_ovf", 32'h8000_0000);
    tick();
    clear_d();
    measure("div_zero_signed", 32'hFFFF_FFFF);

    // Flush in the middle of a divide
    tick();
    set_mdu(3'b100, 32'd100, 32'd7); tick();
    clear_d();
    expect_val(1);
    repeat (10) tick();
    check("flush_div_still_busy", {31'd0, o_busy_E});
    i_flush_E = 1'b1;
    expect_val(0); expect_val(0); expect_val(0); expect_val(32'(DIV_IDLE));
    tick();
    i_flush_E = 1'b0;
    check("flush_div_busy", {31'd0, o_busy_E});
    check("flush_div_wr_en", {31'd0, o_register_file_wr_en_E});
    check("flush_div_alu_out", o_ALU_output_E);
    check("flush_div_state", 32'(dut.u_mdu.state));

    // Reset in the middle of a divide
    set_mdu(3'b111, 32'd100, 32'd7); tick();
    clear_d();
    repeat (5) tick();
    rst = 1'b1;
    expect_val(0); expect_val(0); expect_val(32'(DIV_IDLE));
    tick();
    rst = 1'b0;
    check("rst_div_busy", {31'd0, o_busy_E});
    check("rst_div_wr_en", {31'd0, o_register_file_wr_en_E});
    check("rst_div_state", 32'(dut.u_mdu.state));
`else
    // Without the MDU the flag is ignored and the ALU op executes
    clear_d();
    i_mdu_D = 1'b1; i_funct3_D = 3'b100; i_rd1_D = 7; i_rd2_D = 2; i_register_file_wr_en_D = 1'b1;
    expect_val(9); expect_val(0); expect_val(1);
    tick();
    check("nomdu_alu_out", o_ALU_output_E);
    check("nomdu_busy", {31'd0, o_busy_E});
    check("nomdu_wr_en", {31'd0, o_register_file_wr_en_E});
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
